// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the 4-bit alu slice and the nibble-serial alu_sequencer.
//   AluCmd          - 5-bit command encodings
//   AluCtrlInternal - field view of the 5-bit control word {carry_in, carry_disable, op[2:0]}
//   AluCtrl         - packed union of the raw word and the field view
//   NIBBLE_W        - slice width (4)
package alu_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // Bit 4 is the slice carry_in, so SUB seeds carry 1 while ADD/COMP seed 0.
    // Bit 3 is carry_disable and marks the logic operations.
    typedef enum logic [4:0] {
        CmdAdd  = 5'b0_0_000,
        CmdSub  = 5'b1_0_001,
        CmdComp = 5'b0_0_010,
        CmdAnd  = 5'b0_1_000,
        CmdOr   = 5'b0_1_001,
        CmdXor  = 5'b0_1_010,
        CmdXnor = 5'b0_1_011
    } AluCmd;

    typedef struct packed {
        logic       carry_in;
        logic       carry_disable;
        logic [2:0] op;
    } AluCtrlInternal;

    typedef union packed {
        logic [4:0]     raw;
        AluCtrlInternal f;
    } AluCtrl;

endpackage

// File: rtl/alu.sv
// alu: combinational 4-bit slice.
//   d1, d2     nibble operands
//   ctrl       AluCtrl {carry_in, carry_disable, op}
//   res        nibble result
//   carry_out  ADD carry, SUB/COMP not-borrow of d1 + ~d2 + carry_in; 0 for logic ops
// Arithmetic (carry_disable = 0): op[1:0] == 00 adds, anything else computes d1 + ~d2 + ci.
// Logic (carry_disable = 1): op[1:0] selects AND, OR, XOR, XNOR.
module alu
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] d1,
    input  logic [NIBBLE_W-1:0] d2,
    input  logic [4:0]          ctrl,
    output logic [NIBBLE_W-1:0] res,
    output logic                carry_out
);

    AluCtrl          c;
    logic [NIBBLE_W:0] sum;
    logic            unused_op_msb;

    assign c             = ctrl;
    assign unused_op_msb = c.f.op[2];

    always_comb begin
        sum       = '0;
        res       = '0;
        carry_out = 1'b0;
        if (!c.f.carry_disable) begin
            if (c.f.op[1:0] == 2'b00) begin
                sum = {1'b0, d1} + {1'b0, d2} + {{NIBBLE_W{1'b0}}, c.f.carry_in};
            end else begin
                sum = {1'b0, d1} + {1'b0, ~d2} + {{NIBBLE_W{1'b0}}, c.f.carry_in};
            end
            res       = sum[NIBBLE_W-1:0];
            carry_out = sum[NIBBLE_W];
        end else begin
            unique case (c.f.op[1:0])
                2'b00:   res = d1 & d2;
                2'b01:   res = d1 | d2;
                2'b10:   res = d1 ^ d2;
                default: res = ~(d1 ^ d2);
            endcase
        end
    end

endmodule

// File: rtl/nibble_shifter.sv
// nibble_shifter: WIDTH-bit register with parallel load, nibble read by index and nibble
// write by index. Load has priority over nibble write.
//   clk, rst_n         clock, synchronous active-low reset (clears the register)
//   load, load_data    parallel load
//   idx                nibble index for read and write
//   wr_en, wr_nibble   nibble write at idx
//   data               full register contents
//   rd_nibble          nibble at idx
module nibble_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_data,
    input  logic [IDX_W-1:0]    idx,
    input  logic                wr_en,
    input  logic [NIBBLE_W-1:0] wr_nibble,
    output logic [WIDTH-1:0]    data,
    output logic [NIBBLE_W-1:0] rd_nibble
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end else if (wr_en) begin
            data_q[idx*NIBBLE_W +: NIBBLE_W] <= wr_nibble;
        end
    end

    assign data      = data_q;
    assign rd_nibble = data_q[idx*NIBBLE_W +: NIBBLE_W];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs WIDTH-bit operations on the 4-bit alu slice, one nibble per cycle,
// LSB first, chaining the slice carry_out into the next nibble's carry_in.
//   clk, rst_n                  clock, synchronous active-low reset
//   op_valid/op_ready           request handshake (ready only when idle)
//   op_cmd, op_a, op_b          AluCmd and operands
//   res_valid/res_ready         response handshake
//   res_data, res_carry, res_zero  result, final carry, zero flag
//   res_ovf                     signed overflow (only with ALU_SEQ_OVERFLOW_EN defined)
//   alu_d1, alu_d2, alu_ctrl    slice drive
//   alu_res, alu_carry_out      slice result
// Optional feature macro: ALU_SEQ_OVERFLOW_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [4:0]          op_cmd,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WIDTH-1:0]    res_data,
    output logic                res_carry,
    output logic                res_zero,
`ifdef ALU_SEQ_OVERFLOW_EN
    output logic                res_ovf,
`endif
    output logic [NIBBLE_W-1:0] alu_d1,
    output logic [NIBBLE_W-1:0] alu_d2,
    output logic [4:0]          alu_ctrl,
    input  logic [NIBBLE_W-1:0] alu_res,
    input  logic                alu_carry_out
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    AluCtrl              cmd_q, cmd_d;
    logic                accept, capture;
    logic [WIDTH-1:0]    a_q, b_q, res_q, res_next;
    logic [NIBBLE_W-1:0] a_nib, b_nib, unused_res_nib;

    nibble_shifter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (op_a),
        .idx       (k_q),
        .wr_en     (1'b0),
        .wr_nibble ('0),
        .data      (a_q),
        .rd_nibble (a_nib)
    );

    nibble_shifter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .load_data (op_b),
        .idx       (k_q),
        .wr_en     (1'b0),
        .wr_nibble ('0),
        .data      (b_q),
        .rd_nibble (b_nib)
    );

    nibble_shifter #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_res (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_data ('0),
        .idx       (k_q),
        .wr_en     (capture),
        .wr_nibble (alu_res),
        .data      (res_q),
        .rd_nibble (unused_res_nib)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cmd_q   <= cmd_d;
        end
    end

    // Result as it will look after this cycle's nibble write; feeds the registered zero flag.
    always_comb begin
        res_next = res_q;
        res_next[k_q*NIBBLE_W +: NIBBLE_W] = alu_res;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        cmd_d     = cmd_q;
        accept    = 1'b0;
        capture   = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        alu_d1    = '0;
        alu_d2    = '0;
        alu_ctrl  = '0;
        unique case (state_q)
            StIdle: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    accept  = 1'b1;
                    cmd_d   = op_cmd;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                alu_d1 = a_nib;
                alu_d2 = b_nib;
                // Nibble 0 uses the command's own carry_in as the seed; later nibbles chain.
                if (k_q == '0) begin
                    alu_ctrl = cmd_q.raw;
                end else if (cmd_q.f.carry_disable) begin
                    alu_ctrl = {1'b0, cmd_q.raw[3:0]};
                end else begin
                    alu_ctrl = {carry_q, cmd_q.raw[3:0]};
                end
                capture = 1'b1;
                carry_d = alu_carry_out;
                if (k_q == LAST_IDX) begin
                    zero_d  = (res_next == '0);
                    state_d = StDone;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign res_data  = res_q;
    assign res_carry = cmd_q.f.carry_disable ? 1'b0 : carry_q;
    assign res_zero  = zero_q;

`ifdef ALU_SEQ_OVERFLOW_EN
    logic sa, sb, sr, is_add, is_sub;
    assign sa      = a_q[WIDTH-1];
    assign sb      = b_q[WIDTH-1];
    assign sr      = res_q[WIDTH-1];
    assign is_add  = !cmd_q.f.carry_disable && (cmd_q.f.op == 3'b000);
    assign is_sub  = !cmd_q.f.carry_disable && (cmd_q.f.op == 3'b001);
    assign res_ovf = (is_add && (sa == sb) && (sr != sa)) ||
                     (is_sub && (sa != sb) && (sr != sa));
`else
    logic unused_ab;
    assign unused_ab = ^{a_q, b_q};
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: alu_sequencer paired with the alu slice, WIDTH = 16. Directed cases plus
// random operations checked against an arithmetic reference model.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [4:0]  op_cmd = '0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic [3:0]  alu_d1, alu_d2, alu_res;
    logic [4:0]  alu_ctrl;
    logic        alu_carry_out;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic        res_ovf;
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [4:0]  ctrl_hist [0:7];
    logic [15:0] got_data;
    logic        got_carry, got_zero;
    logic        saw_valid;
    logic [4:0]  cmd_tab [0:6];

    alu_sequencer #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_cmd        (op_cmd),
        .op_a          (op_a),
        .op_b          (op_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_carry     (res_carry),
        .res_zero      (res_zero),
`ifdef ALU_SEQ_OVERFLOW_EN
        .res_ovf       (res_ovf),
`endif
        .alu_d1        (alu_d1),
        .alu_d2        (alu_d2),
        .alu_ctrl      (alu_ctrl),
        .alu_res       (alu_res),
        .alu_carry_out (alu_carry_out)
    );

    alu u_alu (
        .d1        (alu_d1),
        .d2        (alu_d2),
        .ctrl      (alu_ctrl),
        .res       (alu_res),
        .carry_out (alu_carry_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: result, final carry and signed overflow.
    function automatic void model(input logic [4:0] cmd, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic v);
        logic [16:0] s;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (cmd)
            CmdAdd: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            CmdSub: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            CmdComp: c = (a > b);
            CmdAnd:  r = a & b;
            CmdOr:   r = a | b;
            CmdXor:  r = a ^ b;
            CmdXnor: r = ~(a ^ b);
            default: r = '0;
        endcase
    endfunction

    // Issues one operation and checks latency and result. Completes the response handshake
    // only when res_ready is already high.
    task automatic do_op(input logic [4:0] cmd, input logic [15:0] a, input logic [15:0] b,
                         input string tag);
        logic [15:0] er;
        logic        ec, ev;
        model(cmd, a, b, er, ec, ev);
        @(negedge clk);
        op_valid = 1'b1;
        op_cmd   = cmd;
        op_a     = a;
        op_b     = b;
        check($sformatf("%s_op_ready", tag), {31'b0, op_ready}, 32'd1);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        lat = 0;
        while (!res_valid && lat < 20) begin
            if (lat < 8) ctrl_hist[lat] = alu_ctrl;
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("%s_latency", tag), 32'(lat), 32'd4);
        got_data  = res_data;
        got_carry = res_carry;
        got_zero  = res_zero;
        if (cmd != CmdComp) begin
            check($sformatf("%s_data", tag), {16'b0, res_data}, {16'b0, er});
            check($sformatf("%s_zero", tag), {31'b0, res_zero}, {31'b0, er == 16'h0});
        end
        check($sformatf("%s_carry", tag), {31'b0, res_carry}, {31'b0, ec});
`ifdef ALU_SEQ_OVERFLOW_EN
        check($sformatf("%s_ovf", tag), {31'b0, res_ovf}, {31'b0, ev});
`else
        if (ev) lat = lat;
`endif
        if (res_ready) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_done_valid", tag), {31'b0, res_valid}, 32'd0);
        end
    endtask

    initial begin
        cmd_tab[0] = CmdAdd;
        cmd_tab[1] = CmdSub;
        cmd_tab[2] = CmdComp;
        cmd_tab[3] = CmdAnd;
        cmd_tab[4] = CmdOr;
        cmd_tab[5] = CmdXor;
        cmd_tab[6] = CmdXnor;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_ready", {31'b0, op_ready}, 32'd1);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_res_data", {16'b0, res_data}, 32'd0);
        check("rst_res_carry", {31'b0, res_carry}, 32'd0);
        check("rst_res_zero", {31'b0, res_zero}, 32'd0);
        check("rst_alu_ctrl", {27'b0, alu_ctrl}, 32'd0);
        check("rst_alu_d", {24'b0, alu_d1, alu_d2}, 32'd0);
`ifdef ALU_SEQ_OVERFLOW_EN
        check("rst_res_ovf", {31'b0, res_ovf}, 32'd0);
`endif
        rst_n = 1'b1;

        // Directed cases
        do_op(CmdAdd, 16'h00FF, 16'h0001, "add_00ff");
        check("add_00ff_const", {16'b0, got_data}, 32'h0100);
        check("add_00ff_ctrl0", {27'b0, ctrl_hist[0]}, 32'h00);
        check("add_00ff_ctrl1", {27'b0, ctrl_hist[1]}, 32'h10);

        do_op(CmdAdd, 16'hFFFF, 16'h0001, "add_ffff");
        check("add_ffff_const", {14'b0, got_carry, got_zero, got_data}, 32'h0003_0000);
`ifdef ALU_SEQ_OVERFLOW_EN
        do_op(CmdAdd, 16'h7FFF, 16'h0001, "add_7fff");
        check("add_7fff_ovf_const", {31'b0, res_ovf}, 32'd1);
`endif

        do_op(CmdSub, 16'h1000, 16'h0001, "sub_1000");
        check("sub_1000_const", {15'b0, got_carry, got_data}, 32'h0001_0FFF);
        do_op(CmdSub, 16'h0001, 16'h0002, "sub_0001");
        check("sub_0001_const", {15'b0, got_carry, got_data}, 32'h0000_FFFF);

        do_op(CmdComp, 16'h1234, 16'h1233, "comp_gt");
        check("comp_gt_const", {31'b0, got_carry}, 32'd1);
        do_op(CmdComp, 16'h1233, 16'h1234, "comp_lt");
        check("comp_lt_const", {31'b0, got_carry}, 32'd0);

        do_op(CmdAnd, 16'hF0F0, 16'h3C3C, "and");
        check("and_const", {15'b0, got_carry, got_data}, 32'h0000_3030);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("and_ctrl%0d_bit4", k), {31'b0, ctrl_hist[k][4]}, 32'd0);
        end
        do_op(CmdOr, 16'hF0F0, 16'h0F00, "or");
        check("or_const", {16'b0, got_data}, 32'hFFF0);

        // Backpressure: result held for 5 cycles, op_valid pulses ignored
        res_ready = 1'b0;
        do_op(CmdXor, 16'hA5A5, 16'h0FF0, "xor_bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_cmd   = CmdAdd;
            op_a     = 16'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid", i), {31'b0, res_valid}, 32'd1);
            check($sformatf("bp%0d_data", i), {16'b0, res_data}, 32'hAA55);
            check($sformatf("bp%0d_op_ready", i), {31'b0, op_ready}, 32'd0);
        end
        @(negedge clk);
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'b0, res_valid}, 32'd0);
        check("bp_release_ready", {31'b0, op_ready}, 32'd1);
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | res_valid;
        end
        check("bp_nothing_latched", {31'b0, saw_valid}, 32'd0);

        // Reset during nibble 2
        @(negedge clk);
        op_valid = 1'b1;
        op_cmd   = CmdAdd;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_op_ready", {31'b0, op_ready}, 32'd1);
        check("rst_mid_res_valid", {31'b0, res_valid}, 32'd0);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            saw_valid = saw_valid | res_valid;
        end
        check("rst_mid_discarded", {31'b0, saw_valid}, 32'd0);
        do_op(CmdAdd, 16'h0003, 16'h0004, "add_after_rst");
        check("add_after_rst_const", {16'b0, got_data}, 32'h0007);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            do_op(cmd_tab[$urandom_range(0, 6)], 16'($urandom), 16'($urandom),
                  $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Nibble-serial controller that drives the existing 4-bit `alu` slice to run WIDTH-bit operations. It accepts one wide operation over a valid/ready request port and feeds the slice one nibble per cycle, LSB first. Between nibbles it chains the slice's `carry_out` back into the `carry_in` field of `AluCtrl`. It then returns the assembled result and flags over a valid/ready response port. It is the issuing end of the ALU command/operand interface; the `alu` slice is instantiated next to it at the level above.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4; NIBBLES = WIDTH/4.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- op_valid  in  1  request valid.
- op_ready  out  1  request ready; high only in IDLE.
- op_cmd  in  5  AluCmd; `x` bits are treated as 0.
- op_a, op_b  in  WIDTH  operands A and B.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  WIDTH  result.
- res_carry  out  1  final carry (ADD carry, SUB not-borrow, COMP A>B); 0 for logic ops.
- res_zero  out  1  res_data == 0.
- alu_d1, alu_d2  out  4  current nibble of A and B to the slice.
- alu_ctrl  out  5  AluCtrl to the slice.
- alu_res  in  4  slice result.
- alu_carry_out  in  1  slice carry out.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `op_valid && op_ready`. The transfer latches op_a, op_b, op_cmd and sets nibble index k = 0.
  - RUN → RUN while k < NIBBLES-1. Each RUN cycle captures `alu_res` into result nibble k and `alu_carry_out` into carry_q, then increments k.
  - RUN → DONE on the edge that captures nibble NIBBLES-1.
  - DONE → IDLE on `res_valid && res_ready`.
- Slice drive in RUN: `alu_d1` = A[4k+3:4k] and `alu_d2` = B[4k+3:4k].
- `alu_ctrl` in RUN:
  - k = 0: the latched cmd.
  - k > 0 with carry_disable = 0: {carry_q, cmd[3:0]}.
  - k > 0 with carry_disable = 1 (XOR/XNOR/AND/OR): cmd with bit 4 forced 0.
- Carry seeding: SUB starts with carry_in = 1; ADD and COMP start with 0. Chaining needs no decode beyond these bit fields.
- Slice drive outside RUN: `alu_d1` = `alu_d2` = 0 and `alu_ctrl` = 5'b00000.
- `res_carry` = carry_disable ? 0 : carry_q.
- `res_zero` is computed from the registered result.
- Encodings outside the AluCmd set are executed bit-field-wise as given; no error is raised.

## Timing
- Reset value of every output is 0, except `op_ready` = 1 (state IDLE); all registers are cleared.
- Latency: `res_valid` rises exactly NIBBLES edges after the accepting edge (4 for WIDTH = 16).
- The slice is combinational: nibble k is driven and captured within the same RUN cycle.
- Throughput: minimum NIBBLES + 2 cycles per operation, because `op_ready` is low in RUN and DONE.
- `op_valid` asserted during RUN or DONE is ignored and nothing is latched.
- `res_data`, `res_carry` and `res_zero` are held stable while `res_valid && !res_ready`.
- With `res_ready` held high, DONE lasts exactly one cycle.
- `rst_n` low in any state forces IDLE on the next edge; any in-flight operation is discarded and `res_valid` = 0.
- Nibble index k wraps only through IDLE and never exceeds NIBBLES-1.

## Configuration
- `ALU_SEQ_OVERFLOW_EN` defined: adds output `res_ovf` (1 bit, reset 0), computed from sign bits a = A[W-1], b = B[W-1], r = res[W-1]:
  - ADD: (a == b) && (r != a).
  - SUB: (a != b) && (r != a).
  - Otherwise 0.
  - Held with the rest of the result.
- `ALU_SEQ_OVERFLOW_EN` not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `alu_pkg` holds AluCmd, AluCtrlInternal and the AluCtrl union, plus NIBBLE_W = 4. `alu` and `alu_sequencer` both import it.
- FSM state enum {IDLE, RUN, DONE} is local to the module.
- One sub-module, `nibble_shifter`: a WIDTH-bit register with parallel load, nibble select by index, and nibble write by index. It is instantiated for A, B and the result.

## Test plan
Bench pairs `alu_sequencer` with the real `alu` slice, WIDTH = 16.
- ADD 0x00FF + 0x0001 → res 0x0100, carry 0, zero 0. `res_valid` rises 4 edges after accept; `alu_ctrl` is 00000 for nibble 0 and 10000 for nibble 1.
- ADD 0xFFFF + 0x0001 → 0x0000, carry 1, zero 1. With the macro: 0x7FFF + 0x0001 → `res_ovf` 1.
- SUB 0x1000 - 0x0001 → 0x0FFF, carry 1. SUB 0x0001 - 0x0002 → 0xFFFF, carry 0.
- COMP 0x1234 vs 0x1233 → carry 1. COMP 0x1233 vs 0x1234 → carry 0.
- AND 0xF0F0 & 0x3C3C → 0x3030, carry 0, `alu_ctrl` bit 4 = 0 every nibble. OR 0xF0F0 | 0x0F00 → 0xFFF0.
- Backpressure and reset:
  - `res_ready` low for 5 cycles → result held, `op_valid` pulses not accepted.
  - `rst_n` low during nibble 2 → next cycle IDLE, `op_ready` 1, `res_valid` 0.
  - A following ADD 3 + 4 → 0x0007.
